// File: rtl/debounce_scheduler.sv
// debounce_scheduler: time-multiplexed debouncer for a bank of push buttons.
// Every raw input is synchronised continuously. A single sample slot visits one
// channel per prescaler tick, round-robin. Each channel keeps its own saturating
// agreement counter and its debounced level. A channel flips after STABLE_CNT
// consecutive visits that disagree with its current level.
// Optional feature macro: DEBOUNCE_SCHED_PULSE_EN builds the rise/fall pulse
// registers. When the macro is undefined, rise/fall are tied to zero.

module debounce_scheduler #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 8,
    parameter int STABLE_CNT = 12,
    localparam int SLOT_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   in,
    input  logic              scan_en,
    output logic [N_CH-1:0]   out,
    output logic [N_CH-1:0]   rise,
    output logic [N_CH-1:0]   fall,
    output logic [SLOT_W-1:0] slot
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(N_CH - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Two-flop synchroniser stages for the raw button levels
    logic [N_CH-1:0]   sync1_q;
    logic [N_CH-1:0]   sync2_q;

    // Scan state
    logic [PRE_W-1:0]  pre_q,  pre_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [N_CH-1:0]   out_q,  out_d;

    // Sample slot strobe for the channel under slot_q
    logic              tick;
    logic              served_sync;
    logic              served_out;
    logic [CNT_W-1:0]  served_cnt;
    logic              served_flip;

    assign tick        = scan_en && (pre_q == PRE_MAX);
    assign served_sync = sync2_q[slot_q];
    assign served_out  = out_q[slot_q];
    assign served_cnt  = cnt_q[slot_q];
    assign served_flip = tick && (served_sync != served_out) && (served_cnt == CNT_MAX);

    // Synchronisers run regardless of scan_en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    // Next-state for prescaler, slot pointer, served counter and level
    always_comb begin
        pre_d  = pre_q;
        slot_d = slot_q;
        cnt_d  = cnt_q;
        out_d  = out_q;

        if (scan_en) begin
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_ONE;
        end

        if (tick) begin
            slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_ONE;

            if (served_sync == served_out) begin
                cnt_d[slot_q] = '0;
            end else if (served_cnt == CNT_MAX) begin
                cnt_d[slot_q] = '0;
                out_d[slot_q] = served_sync;
            end else begin
                cnt_d[slot_q] = served_cnt + CNT_ONE;
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            slot_q <= '0;
            out_q  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pre_q  <= pre_d;
            slot_q <= slot_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef DEBOUNCE_SCHED_PULSE_EN
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;

    // Edge pulses: only the served channel can flip, so at most one bit is set
    always_comb begin
        rise_d = '0;
        fall_d = '0;
        if (served_flip) begin
            rise_d[slot_q] = served_sync;
            fall_d[slot_q] = ~served_sync;
        end
    end

    // Pulse registers clear every cycle so a pulse lasts exactly one cycle,
    // even if scan_en drops right after it was issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif

    assign out  = out_q;
    assign slot = slot_q;

`ifndef SYNTHESIS
    // Structural invariants of the scheduler
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(rise | fall))
                else $error("more than one edge pulse active");
            assert (slot_q <= SLOT_MAX)
                else $error("slot pointer out of range");
            for (int unsigned i = 0; i < N_CH; i++) begin
                assert (cnt_q[i] <= CNT_MAX)
                    else $error("debounce counter out of range");
            end
        end
    end
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_CH=4, TICK_DIV=8, STABLE_CNT=4.
// Edge numbers in comments count rising clock edges after reset release.
// Channel k is served at edge 8*m when (m-1) mod 4 == k.

module tb_debounce_scheduler;

    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 8;
    localparam int STABLE_CNT = 4;

`ifdef DEBOUNCE_SCHED_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [3:0]      din;
    logic            scan_en;
    logic [3:0]      dout;
    logic [3:0]      rise;
    logic [3:0]      fall;
    logic [1:0]      slot;

    int              checks;
    int              errors;
    logic [3:0]      pulse_seen;

    debounce_scheduler #(
        .N_CH      (N_CH),
        .TICK_DIV  (TICK_DIV),
        .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (din),
        .scan_en(scan_en),
        .out    (dout),
        .rise   (rise),
        .fall   (fall),
        .slot   (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pulse_seen = pulse_seen | rise | fall;
        end
    endtask

    function automatic logic [3:0] pe(input logic [3:0] v);
        return PULSE_EN ? v : 4'b0000;
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        pulse_seen = '0;
        reset      = 1'b1;
        din        = 4'b0000;
        scan_en    = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",  dout, 4'b0000);
        check("rst_rise", rise, 4'b0000);
        check("rst_fall", fall, 4'b0000);
        check("rst_slot", slot, 2'd0);
        reset = 1'b0;                       // edge 0

        // Slot stepping with idle inputs
        step(7);  check("slot_e7",  slot, 2'd0);
        step(1);  check("slot_e8",  slot, 2'd1);
        step(8);  check("slot_e16", slot, 2'd2);
        step(8);  check("slot_e24", slot, 2'd3);
        step(8);  check("slot_e32", slot, 2'd0);
        check("idle_out",   dout, 4'b0000);
        check("idle_pulse", pulse_seen, 4'b0000);
        step(8);                            // edge 40

        // in[2] held high: ch2 visits at 56,88,120,152, flip at 152
        din = 4'b0100;
        step(111); check("ch2_before", dout, 4'b0000);
        step(1);   check("ch2_out",  dout, 4'b0100);
                   check("ch2_rise", rise, pe(4'b0100));
                   check("ch2_fall", fall, 4'b0000);
        step(1);   check("ch2_rise_end", rise, 4'b0000);
        step(-1 + 0);                       // no-op keeps edge numbering explicit

        // Glitch on in[1]: ch1 visits 176,208,240 (1), 272 (0), 304,336,368 (1), 400 (0)
        // Currently at edge 153.
        din = 4'b0110;
        step(87);                           // edge 240
        din = 4'b0100;
        step(32);                           // edge 272
        din = 4'b0110;
        pulse_seen = '0;
        step(96);                           // edge 368
        din = 4'b0100;
        step(32);                           // edge 400
        check("glitch_out",   dout, 4'b0100);
        check("glitch_pulse", pulse_seen, 4'b0000);

        // All high: ch3 flips at 512, ch0 at 520, ch1 at 528
        din = 4'b1111;
        step(111); check("all_before", dout, 4'b0100);
        step(1);   check("all_e512_out",  dout, 4'b1100);
                   check("all_e512_rise", rise, pe(4'b1000));
        step(8);   check("all_e520_out",  dout, 4'b1101);
                   check("all_e520_rise", rise, pe(4'b0001));
        step(8);   check("all_e528_out",  dout, 4'b1111);
                   check("all_e528_rise", rise, pe(4'b0010));
        step(16);  check("slot_e544", slot, 2'd0);

        // All low from edge 544: falls at 648,656,664,672 in channel order
        din = 4'b0000;
        pulse_seen = '0;
        step(103); check("fall_before_out", dout, 4'b1111);
                   check("fall_before_pls", pulse_seen, 4'b0000);
        step(1);   check("fall0_out", dout, 4'b1110);
                   check("fall0",     fall, pe(4'b0001));
        step(8);   check("fall1_out", dout, 4'b1100);
                   check("fall1",     fall, pe(4'b0010));
        step(8);   check("fall2_out", dout, 4'b1000);
                   check("fall2",     fall, pe(4'b0100));
        step(8);   check("fall3_out", dout, 4'b0000);
                   check("fall3",     fall, pe(4'b1000));
        step(1);   check("fall3_end", fall, 4'b0000);

        // scan_en freeze: ch3 visited at 704,736, then 100 frozen cycles
        // Currently at edge 673.
        din = 4'b1000;
        step(63);                           // edge 736
        check("frz_slot_pre", slot, 2'd0);
        scan_en = 1'b0;
        step(100);                          // edge 836
        check("frz_slot", slot, 2'd0);
        check("frz_out",  dout, 4'b0000);
        scan_en = 1'b1;
        step(8);   check("resume_slot", slot, 2'd1);   // edge 844
        step(55);  check("resume_before", dout, 4'b0000);
        step(1);   check("resume_out",  dout, 4'b1000); // edge 900
                   check("resume_rise", rise, pe(4'b1000));

        // Pending flip on ch0 at edge 1004, reset lands in that cycle
        din = 4'b1001;
        step(103);                          // edge 1003
        check("pend_before", dout, 4'b1000);
        reset = 1'b1;
        #1;
        check("rst_mid_out",  dout, 4'b0000);
        check("rst_mid_slot", slot, 2'd0);
        pulse_seen = '0;
        step(3);
        check("rst_hold_out", dout, 4'b0000);
        reset = 1'b0;                       // new edge 0
        step(7);   check("rel_slot_e7", slot, 2'd0);
        step(1);   check("rel_slot_e8", slot, 2'd1);
        check("rel_out",   dout, 4'b0000);
        check("rel_pulse", pulse_seen, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard so the run always terminates
    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
